edge_filter_multi: RTL and testbench

EDGE_FILTER_MULTI -- requirements
Module: edge_filter_multi

---
 rtl/edge_filter_multi_pkg.sv | 12 +
 rtl/edge_filter_multi_if.sv | 22 ++
 rtl/edge_filter_multi_ch.sv | 69 ++++++
 rtl/edge_filter_multi.sv | 29 ++
 tb/tb_edge_filter_multi.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/edge_filter_multi_pkg.sv
// edge_filter_pkg: shared defaults, idle level and channel state layout for the edge filter
package edge_filter_pkg;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_CNT = 3;
  localparam logic IDLE_LVL = 1'b1;
  typedef struct packed {
    logic [DEF_SYNC_STAGES-1:0]        sync;
    logic                              filt;
    logic [$clog2(DEF_FILT_CNT+1)-1:0] cnt;
  } ch_state_t;
endpackage

// File: rtl/edge_filter_multi_if.sv
// edge_filter_multi_if: line/enable bundle; EDGE_FILTER_STICKY_EN adds the sticky flags
interface edge_filter_multi_if #(parameter int NUM_CH = 2);
  logic              en;
  logic [NUM_CH-1:0] line_in;
  logic [NUM_CH-1:0] line_filt;
  logic [NUM_CH-1:0] rising_edge_found;
  logic [NUM_CH-1:0] falling_edge_found;
`ifdef EDGE_FILTER_STICKY_EN
  logic              clr_sticky;
  logic [NUM_CH-1:0] rise_seen;
  logic [NUM_CH-1:0] fall_seen;
  modport master (output en, line_in, clr_sticky,
                  input line_filt, rising_edge_found, falling_edge_found, rise_seen, fall_seen);
  modport slave (input en, line_in, clr_sticky,
                 output line_filt, rising_edge_found, falling_edge_found, rise_seen, fall_seen);
`else
  modport master (output en, line_in,
                  input line_filt, rising_edge_found, falling_edge_found);
  modport slave (input en, line_in,
                 output line_filt, rising_edge_found, falling_edge_found);
`endif
endinterface

// File: rtl/edge_filter_multi_ch.sv
// edge_filter_ch: one line's synchroniser, stability counter and edge pulses (EDGE_FILTER_STICKY_EN adds sticky flags)
module edge_filter_ch
  import edge_filter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CNT    = DEF_FILT_CNT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en_i,
  input  logic line_i,
`ifdef EDGE_FILTER_STICKY_EN
  input  logic clr_sticky_i,
  output logic rise_seen_o,
  output logic fall_seen_o,
`endif
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(FILT_CNT+1);
  typedef struct packed {
    logic [SYNC_STAGES-1:0] sync;
    logic                   filt;
    logic [CW-1:0]          cnt;
  } st_t;
  localparam st_t ST_RST = '{sync: {SYNC_STAGES{IDLE_LVL}}, filt: IDLE_LVL, cnt: '0};
  st_t  st_q, st_d;
  logic rise_q, rise_d, fall_q, fall_d;
  logic sync, accept;
  // next state: accept a new level once it has differed for FILT_CNT enabled cycles
  always_comb begin
    sync = st_q.sync[SYNC_STAGES-1];
    accept = en_i && sync != st_q.filt && st_q.cnt == CW'(FILT_CNT-1);
    st_d.sync = {st_q.sync[SYNC_STAGES-2:0], line_i};
    st_d.filt = accept ? sync : st_q.filt;
    st_d.cnt = !en_i ? st_q.cnt : (sync == st_q.filt || accept) ? '0 : st_q.cnt + 1'b1;
    rise_d = accept && sync;
    fall_d = accept && !sync;
  end
  // state and pulse registers, idle-high on reset
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      st_q <= ST_RST;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      st_q <= st_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  assign filt_o = st_q.filt;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`ifdef EDGE_FILTER_STICKY_EN
  logic rise_seen_q, fall_seen_q;
  // sticky flags latch the visible pulse; a pulse wins over a same-cycle clear
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      rise_seen_q <= 1'b0;
      fall_seen_q <= 1'b0;
    end else begin
      rise_seen_q <= rise_q ? 1'b1 : clr_sticky_i ? 1'b0 : rise_seen_q;
      fall_seen_q <= fall_q ? 1'b1 : clr_sticky_i ? 1'b0 : fall_seen_q;
    end
  assign rise_seen_o = rise_seen_q;
  assign fall_seen_o = fall_seen_q;
`endif
endmodule

// File: rtl/edge_filter_multi.sv
// edge_filter_multi: NUM_CH independent glitch filters with edge pulses (EDGE_FILTER_STICKY_EN adds sticky flags)
module edge_filter_multi
  import edge_filter_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CNT    = DEF_FILT_CNT
) (
  input logic clk,
  input logic n_rst,
  edge_filter_multi_if.slave bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_filter_ch #(.SYNC_STAGES(SYNC_STAGES), .FILT_CNT(FILT_CNT)) u_ch (
      .clk          (clk),
      .n_rst        (n_rst),
      .en_i         (bus.en),
      .line_i       (bus.line_in[i]),
`ifdef EDGE_FILTER_STICKY_EN
      .clr_sticky_i (bus.clr_sticky),
      .rise_seen_o  (bus.rise_seen[i]),
      .fall_seen_o  (bus.fall_seen[i]),
`endif
      .filt_o       (bus.line_filt[i]),
      .rise_o       (bus.rising_edge_found[i]),
      .fall_o       (bus.falling_edge_found[i])
    );
  end
endmodule

// File: tb/tb_edge_filter_multi.sv
// tb_edge_filter_multi: scoreboard bench with a run-length reference model
module tb_edge_filter_multi;
  localparam int NCH = 2;
  localparam int S = 2;
  localparam int F = 3;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;
  edge_filter_multi_if #(.NUM_CH(NCH)) bus();
  edge_filter_multi #(.NUM_CH(NCH), .SYNC_STAGES(S), .FILT_CNT(F)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );
  typedef struct {
    logic [NCH-1:0] filt, rise, fall, rseen, fseen;
  } exp_t;
  exp_t sbq[$];
  exp_t cur;
  int errors = 0;
  int checks = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  bit hist[NCH][S];
  bit mfilt[NCH];
  int run[NCH];
  // reference model: a level is accepted after F consecutive enabled cycles of disagreement
  always @(posedge clk) begin
    exp_t nxt;
    bit s;
    nxt = '{default: '0};
    for (int c = 0; c < NCH; c++) begin
      if (!n_rst) begin
        for (int k = 0; k < S; k++) hist[c][k] = 1'b1;
        mfilt[c] = 1'b1;
        run[c] = 0;
      end else begin
        s = hist[c][S-1];
        for (int k = S-1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = bus.line_in[c];
        if (bus.en) begin
          if (s != mfilt[c]) begin
            run[c]++;
            if (run[c] == F) begin
              mfilt[c] = s;
              nxt.rise[c] = s;
              nxt.fall[c] = !s;
              run[c] = 0;
            end
          end else run[c] = 0;
        end
`ifdef EDGE_FILTER_STICKY_EN
        nxt.rseen[c] = cur.rise[c] ? 1'b1 : bus.clr_sticky ? 1'b0 : cur.rseen[c];
        nxt.fseen[c] = cur.fall[c] ? 1'b1 : bus.clr_sticky ? 1'b0 : cur.fseen[c];
`endif
      end
      nxt.filt[c] = mfilt[c];
    end
    cur = nxt;
    sbq.push_back(nxt);
  end
  // monitor: compare the DUT's registered outputs mid-cycle against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (!n_rst) e = '{filt: '1, rise: '0, fall: '0, rseen: '0, fseen: '0};
      checks++;
      if (bus.line_filt !== e.filt || bus.rising_edge_found !== e.rise || bus.falling_edge_found !== e.fall) begin
        errors++;
        $display("FAIL outs t=%0t got filt=%b rise=%b fall=%b want filt=%b rise=%b fall=%b", $time,
                 bus.line_filt, bus.rising_edge_found, bus.falling_edge_found, e.filt, e.rise, e.fall);
      end
`ifdef EDGE_FILTER_STICKY_EN
      checks++;
      if (bus.rise_seen !== e.rseen || bus.fall_seen !== e.fseen) begin
        errors++;
        $display("FAIL sticky t=%0t got rise_seen=%b fall_seen=%b want %b %b", $time,
                 bus.rise_seen, bus.fall_seen, e.rseen, e.fseen);
      end
`endif
      checks++;
      if ((bus.rising_edge_found & bus.falling_edge_found) !== '0) begin
        errors++;
        $display("FAIL exclusive t=%0t rise=%b fall=%b want no overlap", $time,
                 bus.rising_edge_found, bus.falling_edge_found);
      end
      rise_cnt += $countones(bus.rising_edge_found);
      fall_cnt += $countones(bus.falling_edge_found);
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  task automatic wait_pulse(input int ch, input bit rising, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (n < 20 && !(rising ? bus.rising_edge_found[ch] : bus.falling_edge_found[ch]));
  endtask
  initial begin
    int n, p0;
    bus.en = 1'b1;
    bus.line_in = '1;
`ifdef EDGE_FILTER_STICKY_EN
    bus.clr_sticky = 1'b0;
`endif
    step(3);
    check("rst_filt", 32'(bus.line_filt), 32'h3);
    check("rst_rise", 32'(bus.rising_edge_found), 0);
    check("rst_fall", 32'(bus.falling_edge_found), 0);
    n_rst = 1'b1;
    step(6);
    check("idle_filt", 32'(bus.line_filt), 32'h3);
    bus.line_in[0] = 1'b0;
    wait_pulse(0, 1'b0, n);
    check("fall_latency", n, S + F);
    check("fall_filt_now", 32'(bus.line_filt[0]), 0);
    step(1);
    check("fall_one_cycle", 32'(bus.falling_edge_found[0]), 0);
    check("fall_filt_held", 32'(bus.line_filt[0]), 0);
    p0 = rise_cnt + fall_cnt;
    for (int g = 0; g < 2; g++) begin
      bus.line_in[1] = 1'b0;
      step(2);
      bus.line_in[1] = 1'b1;
      step(8);
    end
    check("glitch_filt", 32'(bus.line_filt), 32'h2);
    check("glitch_pulses", rise_cnt + fall_cnt - p0, 0);
    bus.line_in = 2'b00;
    step(10);
    bus.line_in = 2'b11;
    wait_pulse(0, 1'b1, n);
    check("both_rise", 32'(bus.rising_edge_found), 32'h3);
    check("both_nofall", 32'(bus.falling_edge_found), 0);
    step(3);
    bus.en = 1'b0;
    bus.line_in[0] = 1'b0;
    p0 = fall_cnt;
    step(10);
    check("en0_filt", 32'(bus.line_filt[0]), 1);
    check("en0_pulses", fall_cnt - p0, 0);
    bus.en = 1'b1;
    wait_pulse(0, 1'b0, n);
    check("en_latency", n, F);
    step(3);
    bus.line_in[0] = 1'b1;
    step(S + F - 1);
    n_rst = 1'b0;
    #1;
    check("midrst_filt", 32'(bus.line_filt), 32'h3);
    check("midrst_rise", 32'(bus.rising_edge_found), 0);
    p0 = rise_cnt + fall_cnt;
    step(2);
    n_rst = 1'b1;
    step(8);
    check("postrst_pulses", rise_cnt + fall_cnt - p0, 0);
    check("postrst_filt", 32'(bus.line_filt), 32'h3);
`ifdef EDGE_FILTER_STICKY_EN
    bus.line_in[0] = 1'b0;
    step(10);
    bus.clr_sticky = 1'b1;
    step(1);
    bus.clr_sticky = 1'b0;
    bus.line_in[0] = 1'b1;
    wait_pulse(0, 1'b1, n);
    bus.clr_sticky = 1'b1;
    step(1);
    check("sticky_set_wins", 32'(bus.rise_seen[0]), 1);
    step(1);
    check("sticky_clear", 32'(bus.rise_seen[0]), 0);
    bus.clr_sticky = 1'b0;
`endif
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(5) == 0) bus.line_in[c] = ~bus.line_in[c];
      bus.en = $urandom_range(9) != 0;
`ifdef EDGE_FILTER_STICKY_EN
      bus.clr_sticky = $urandom_range(7) == 0;
`endif
      if ($urandom_range(499) == 0) begin
        n_rst = 1'b0;
        step(1);
        n_rst = 1'b1;
      end
      step(1);
    end
    step(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
